shift_seq_ctrl: RTL and testbench
=================================

Name: shift_seq_ctrl

Overview:
- Sequencing controller for the shifter datapath: accepts one operand, shift amount and shift type over a valid/ready handshake.
- Performs the multi-bit shift iteratively, one bit per clock, through a single 1-bit shift stage.
- Returns the result over a second valid/ready handshake.
- Sits between a requesting FSM and downstream logic; trades latency for area against a full barrel shifter.

Parameters:
- W, 8, operand/result width in bits (W >= 2).
- AW, $clog2(W), width of the shift-amount field (derived; not overridden).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- clear  input  1  synchronous abort; returns block to IDLE.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request.
- in_data  input  W  operand.
- in_amt  input  AW  shift amount, 0..W-1.
- in_op  input  2  shift type (shift_op_t).
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- out_data  output  W  result.
- busy  output  1  high in SHIFT or DONE.
- op_count  output  8  count of completed output handshakes; wraps 255->0.

Behaviour:
- Clock/reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values: state=IDLE; data_q=0; cnt_q=0; op_q=SLL; out_valid=0; out_data=0; busy=0; op_count=0.
- in_ready = (state==IDLE) && rst_n. out_valid = (state==DONE). out_data = data_q.
- Op encodings:
  - SLL=0: shift left, 0 into LSB.
  - SRL=1: shift right, 0 into MSB.
  - SRA=2: shift right, MSB replicated.
  - ROL=3: rotate left, old MSB into LSB.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On in_valid && in_ready: latch data_q=in_data, op_q=in_op, cnt_q=in_amt.
  - Next state is DONE if in_amt==0, else SHIFT.
- SHIFT:
  - Each edge: data_q = step(data_q, op_q); cnt_q--.
  - When cnt_q==1 at the edge, go to DONE.
  - in_valid is ignored.
- DONE:
  - Hold data_q stable while out_ready=0 (no change in out_data, no other state change).
  - On out_ready: op_count++, go to IDLE.
  - No new request is accepted in the same cycle; the next accept is earliest one cycle later.
- Latency: out_valid rises on the in_amt-th edge after the accepting edge. For in_amt=0 it rises on the accepting edge itself.
- Throughput: one request per in_amt+2 cycles when out_ready is held high.
- clear (sampled when rst_n=1):
  - Overrides everything; next state IDLE, out_valid=0, cnt_q=0.
  - data_q keeps its value; op_count is not incremented, even if out_ready is also high in DONE.
- rst_n low mid-operation: immediate return to reset values; in-flight request lost.
- Arithmetic: cnt_q is AW bits, never decremented below 0. in_amt >= W cannot occur because of AW sizing (for W a power of 2, all codes are legal).
- No X propagation: in_op and in_data are only sampled on accept.

Decomposition:
- Package shift_pkg:
  - typedef enum logic [1:0] shift_op_t {SLL, SRL, SRA, ROL}.
  - typedef enum logic [1:0] state_t {IDLE, SHIFT, DONE}.
- Sub-module shift_step, purely combinational: W-bit in, shift_op_t op, W-bit out, one-position shift.
- Controller shift_seq_ctrl holds the FSM, registers and handshakes, and instantiates one shift_step.

Test Plan:
- Reset, then SLL in_data=0x81, amt=3, out_ready=1 -> out_data=0x08; out_valid on 3rd edge after accept; op_count=1; in_ready returns 1 the cycle after.
- SRA 0x90 amt=2 -> 0xE4. SRL 0x90 amt=2 -> 0x24. ROL 0x81 amt=7 -> 0xC0.
- SRL 0xFF amt=0 -> out_valid on accepting edge, out_data=0xFF.
- Backpressure: SLL 0x01 amt=1 with out_ready=0 for 5 cycles and in_valid=1 throughout -> out_data stays 0x02, in_ready=0, no second accept; release -> op_count+1, then accept.
- clear during SHIFT (SLL 0x01 amt=6, clear after 2 edges) -> IDLE next edge, out_valid never asserted, op_count unchanged. Repeat with rst_n pulsed low mid-SHIFT -> all outputs at reset values while rst_n=0.
- 256 back-to-back amt=0 ops -> op_count wraps to 0; busy high exactly in SHIFT/DONE cycles.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types for the iterative shifter: shift operation codes and controller states.
package shift_pkg;

    typedef enum logic [1:0] {
        SLL = 2'd0,
        SRL = 2'd1,
        SRA = 2'd2,
        ROL = 2'd3
    } shift_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_step.sv
// Single-position shift/rotate stage; the controller iterates it once per clock.
module shift_step
    import shift_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] data_i,
    input  shift_op_t    op_i,
    output logic [W-1:0] data_o
);

    always_comb begin
        data_o = data_i;
        case (op_i)
            SLL: data_o = {data_i[W-2:0], 1'b0};
            SRL: data_o = {1'b0, data_i[W-1:1]};
            SRA: data_o = {data_i[W-1], data_i[W-1:1]};
            ROL: data_o = {data_i[W-2:0], data_i[W-1]};
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencing controller: accepts one shift request, performs it one bit per
// clock through shift_step, then holds the result until the consumer takes it.
module shift_seq_ctrl
    import shift_pkg::*;
#(
    parameter int W  = 8,
    parameter int AW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic [AW-1:0] in_amt,
    input  logic [1:0]    in_op,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          busy,
    output logic [7:0]    op_count
);

    state_t        state_q, state_d;
    logic [W-1:0]  data_q, data_d, step_data;
    logic [AW-1:0] cnt_q, cnt_d;
    shift_op_t     op_q, op_d;
    logic [7:0]    op_count_q, op_count_d;
    logic          accept;

    assign accept = in_valid && in_ready;

    shift_step #(.W(W)) u_step (
        .data_i (data_q),
        .op_i   (op_q),
        .data_o (step_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept) state_d = (in_amt == '0) ? DONE : SHIFT;
                SHIFT:   if (cnt_q <= AW'(1)) state_d = DONE;
                DONE:    if (out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state_q == IDLE) && rst_n;
        out_valid = (state_q == DONE);
        busy      = (state_q == SHIFT) || (state_q == DONE);
    end

    // clear keeps the operand register untouched; only the count is dropped
    always_comb begin
        data_d     = data_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        op_count_d = op_count_q;
        if (clear) begin
            cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        data_d = in_data;
                        cnt_d  = in_amt;
                        op_d   = shift_op_t'(in_op);
                    end
                end
                SHIFT: begin
                    data_d = step_data;
                    if (cnt_q != '0) cnt_d = cnt_q - AW'(1);
                end
                DONE: begin
                    if (out_ready) op_count_d = op_count_q + 8'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q     <= '0;
            cnt_q      <= '0;
            op_q       <= SLL;
            op_count_q <= '0;
        end else begin
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            op_count_q <= op_count_d;
        end
    end

    assign out_data = data_q;
    assign op_count = op_count_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench for shift_seq_ctrl: the driver pushes expected results on accept,
// the monitor pops and compares on every output handshake.
module tb_shift_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic [2:0] in_amt = 3'd0;
    logic [1:0] in_op = 2'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       busy;
    logic [7:0] op_count;

    typedef struct {
        logic [7:0] data;
        int         amt;
        int         acc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   rdy_mode = 0;
    logic [7:0] exp_cnt = 8'd0;
    logic inflight = 1'b0;
    logic seen = 1'b0;

    shift_seq_ctrl #(.W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] ref_shift(input logic [7:0] d, input int amt, input int op);
        logic signed [7:0] s;
        logic [7:0] r;
        s = d;
        case (op)
            0:       r = d << amt;
            1:       r = d >> amt;
            2:       r = s >>> amt;
            default: r = (amt == 0) ? d : ((d << amt) | (d >> (8 - amt)));
        endcase
        return r;
    endfunction

    // Called right after a rising edge; returns right after the accepting edge.
    task automatic send(input logic [7:0] d, input int amt, input int op, input bit hold);
        bit ok;
        exp_t e;
        in_data  = d;
        in_amt   = amt[2:0];
        in_op    = op[1:0];
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else begin
            e.data = ref_shift(d, amt, op);
            e.amt  = amt;
            e.acc  = cyc + 1;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            if (q.size() == 0 && !inflight) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        if (!ok) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    // Monitor: reference of visible state is "a request is in flight between its
    // accept and its output handshake (or clear)".
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_outputs", {in_ready, out_valid, busy, out_data, op_count}, 32'd0);
            exp_cnt  = 8'd0;
            inflight = 1'b0;
            seen     = 1'b0;
            q.delete();
        end else begin
            chk("op_count", op_count, exp_cnt);
            chk("busy", busy, inflight);
            chk("in_ready", in_ready, !inflight);
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", 32'd0, 32'd1);
                end else begin
                    chk("out_data", out_data, q[0].data);
                    if (!seen) begin
                        chk("latency", cyc, q[0].acc + q[0].amt);
                        seen = 1'b1;
                    end
                end
            end
            if (clear) begin
                if (inflight && q.size() != 0) void'(q.pop_front());
                inflight = 1'b0;
                seen     = 1'b0;
            end else if (out_valid && out_ready) begin
                if (q.size() != 0) void'(q.pop_front());
                exp_cnt  = exp_cnt + 8'd1;
                inflight = 1'b0;
                seen     = 1'b0;
            end else if (in_valid && in_ready) begin
                inflight = 1'b1;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] cnt0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        rdy_mode = 1;
        @(posedge clk); #1;

        // directed cases
        send(8'h81, 3, 0, 1'b0); wait_idle();
        send(8'h90, 2, 2, 1'b0); wait_idle();
        send(8'h90, 2, 1, 1'b0); wait_idle();
        send(8'h81, 7, 3, 1'b0); wait_idle();
        send(8'hFF, 0, 1, 1'b0); wait_idle();

        // backpressure with a second request held pending
        rdy_mode = 0;
        repeat (2) @(posedge clk); #1;
        send(8'h01, 1, 0, 1'b1);
        repeat (6) @(posedge clk); #1;
        rdy_mode = 1;
        send(8'h01, 1, 0, 1'b0);
        wait_idle();

        // clear mid-shift
        send(8'h01, 6, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        wait_idle();

        // asynchronous reset mid-shift
        send(8'h01, 6, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        chk("async_reset_immediate", {in_ready, out_valid, busy, out_data, op_count}, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // randomized traffic with random backpressure
        rdy_mode = 2;
        for (int i = 0; i < 60; i++) begin
            send(8'($urandom), $urandom_range(0, 7), $urandom_range(0, 3), 1'b0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        rdy_mode = 1;
        wait_idle();

        // 256 back-to-back zero-amount ops: counter must come back around
        cnt0 = exp_cnt;
        for (int i = 0; i < 256; i++) send(8'($urandom), 0, $urandom_range(0, 3), 1'b1);
        in_valid = 1'b0;
        wait_idle();
        chk("op_count_wrap", op_count, cnt0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
